// File: rtl/pattern_pkg.sv
// Shared pattern IDs, generator count and scheduler state encoding for the
// VGA pattern pipeline.
package pattern_pkg;

  localparam int unsigned NUM_PATTERNS = 3;

  localparam logic [1:0] PATTERN_CHECKERBOARD = 2'd0;
  localparam logic [1:0] PATTERN_RADIENT      = 2'd1;
  localparam logic [1:0] PATTERN_SPIRAL       = 2'd2;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } sched_state_e;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; RST_VAL seeds the history flop so a level
// that is already high at reset release can be kept from looking like an edge.
module rise_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= RST_VAL;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/pattern_scheduler.sv
// Frame-synchronous owner selection for the pattern generators.
// Define PATTERN_SCHED_BLANK_EN to build the blanked transition between patterns.
module pattern_scheduler #(
  parameter int unsigned NUM_PATTERNS       = pattern_pkg::NUM_PATTERNS,
  parameter int unsigned FRAMES_PER_PATTERN = 300,
  parameter int unsigned BLANK_FRAMES       = 4,
  parameter int unsigned CNT_W              = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vsync,
  input  logic                    btn_next,
  input  logic                    btn_pause,
  input  logic                    auto_en,
  output logic [1:0]              pattern_sel,
  output logic [NUM_PATTERNS-1:0] next_frame,
  output logic [NUM_PATTERNS-1:0] pattern_rst,
  output logic                    blank,
  output logic                    paused
);
  import pattern_pkg::*;

  if (BLANK_FRAMES < 1) begin : g_bad_blank
    $error("BLANK_FRAMES must be at least 1");
  end
  if (FRAMES_PER_PATTERN < 1 || FRAMES_PER_PATTERN > (1 << CNT_W)) begin : g_bad_dwell
    $error("FRAMES_PER_PATTERN-1 must fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);
  localparam logic [1:0]       LAST_ID    = 2'(NUM_PATTERNS - 1);

  logic ft;
  logic next_rise;
  logic pause_rise;

  rise_detect #(.RST_VAL(1'b1)) u_vsync_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (vsync),
    .rise  (ft)
  );

  rise_detect #(.RST_VAL(1'b0)) u_next_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_next),
    .rise  (next_rise)
  );

  rise_detect #(.RST_VAL(1'b0)) u_pause_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_pause),
    .rise  (pause_rise)
  );

  logic [1:0]              sel_q, sel_d;
  logic [NUM_PATTERNS-1:0] next_frame_q, next_frame_d;
  logic [NUM_PATTERNS-1:0] pattern_rst_q, pattern_rst_d;
  logic                    paused_q, paused_d;
  logic                    pending_q, pending_d;
  logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;

  logic [1:0]              next_id;
  logic                    advance;
  logic [CNT_W-1:0]        frame_cnt_step;

  // Dwell counter saturates so auto_en can be raised late and still advance.
  always_comb begin
    next_id        = (sel_q == LAST_ID) ? PATTERN_CHECKERBOARD : sel_q + 2'd1;
    advance        = pending_q | (auto_en & ~paused_q & (frame_cnt_q == DWELL_LAST));
    frame_cnt_step = frame_cnt_q;
    if (!paused_q && frame_cnt_q != DWELL_LAST) begin
      frame_cnt_step = frame_cnt_q + CNT_W'(1);
    end
  end

`ifdef PATTERN_SCHED_BLANK_EN
  localparam int unsigned      BLK_W    = $clog2(BLANK_FRAMES + 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_FRAMES - 1);

  sched_state_e     state_q, state_d;
  logic [BLK_W-1:0] blank_cnt_q, blank_cnt_d;
  logic             blank_q, blank_d;

  always_comb begin
    state_d       = state_q;
    blank_cnt_d   = blank_cnt_q;
    blank_d       = blank_q;
    sel_d         = sel_q;
    next_frame_d  = '0;
    pattern_rst_d = '0;
    frame_cnt_d   = frame_cnt_q;
    pending_d     = pending_q | next_rise;
    paused_d      = paused_q ^ pause_rise;

    case (state_q)
      SHOW: begin
        if (ft) begin
          if (!paused_q) begin
            next_frame_d = NUM_PATTERNS'(1) << sel_q;
          end
          if (advance) begin
            state_d     = BLANK;
            pending_d   = 1'b0;
            frame_cnt_d = '0;
            blank_d     = 1'b1;
            blank_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_step;
          end
        end
      end
      BLANK: begin
        pending_d = pending_q;
        if (ft) begin
          if (blank_cnt_q == BLK_LAST) begin
            state_d       = SHOW;
            sel_d         = next_id;
            pattern_rst_d = NUM_PATTERNS'(1) << next_id;
            blank_d       = 1'b0;
            blank_cnt_d   = '0;
          end else begin
            blank_cnt_d = blank_cnt_q + BLK_W'(1);
          end
        end
      end
      default: state_d = SHOW;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SHOW;
      blank_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      blank_q     <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  // Without the blanked gap the switching frame belongs to neither pattern's animation.
  always_comb begin
    sel_d         = sel_q;
    next_frame_d  = '0;
    pattern_rst_d = '0;
    frame_cnt_d   = frame_cnt_q;
    pending_d     = pending_q | next_rise;
    paused_d      = paused_q ^ pause_rise;

    if (ft) begin
      if (advance) begin
        sel_d         = next_id;
        pattern_rst_d = NUM_PATTERNS'(1) << next_id;
        pending_d     = 1'b0;
        frame_cnt_d   = '0;
      end else begin
        if (!paused_q) begin
          next_frame_d = NUM_PATTERNS'(1) << sel_q;
        end
        frame_cnt_d = frame_cnt_step;
      end
    end
  end

  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q         <= PATTERN_CHECKERBOARD;
      next_frame_q  <= '0;
      pattern_rst_q <= '0;
      paused_q      <= 1'b0;
      pending_q     <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      sel_q         <= sel_d;
      next_frame_q  <= next_frame_d;
      pattern_rst_q <= pattern_rst_d;
      paused_q      <= paused_d;
      pending_q     <= pending_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign pattern_sel = sel_q;
  assign next_frame  = next_frame_q;
  assign pattern_rst = pattern_rst_q;
  assign paused      = paused_q;

endmodule
